// File: rtl/lift_call_dispatcher_if.sv
// Signal bundle between the lift call dispatcher and its surroundings:
// button/floor/arrival inputs and the request, lamp and status outputs.
interface lift_call_dispatcher_if;
  logic [3:0] in_btn;
  logic [2:0] in_cur_f;
  logic       in_reached;
  logic [1:0] o_f;
  logic       o_valid;
  logic [3:0] o_pending;
  logic       o_dir;
  logic       o_busy;
  logic       o_timeout;

  modport master (
    output in_btn, in_cur_f, in_reached,
    input  o_f, o_valid, o_pending, o_dir, o_busy, o_timeout
  );

  modport slave (
    input  in_btn, in_cur_f, in_reached,
    output o_f, o_valid, o_pending, o_dir, o_busy, o_timeout
  );
endinterface

// File: rtl/lift_call_dispatcher.sv
// Four-floor call dispatcher: latches button calls, picks the next target in
// SCAN order, waits for the lift to arrive (or gives up) and clears the call.
module lift_call_dispatcher #(
  parameter int TIMEOUT = 64
) (
  input logic                   in_clk,
  input logic                   in_rst_n,
  lift_call_dispatcher_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_DISPATCH = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_CLEAR    = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic       dir_q, dir_d;
  logic [1:0] f_q, f_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic [1:0] cur_idx;
  logic [3:0] ge_mask, le_mask;
  logic [3:0] up_hits, below_hits, down_hits, above_hits;
  logic [1:0] sel_f;
  logic       sel_dir;
  logic       arrived;
  logic [3:0] clr_mask;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_idx = 2'(i);
    end
  endfunction

  function automatic logic [1:0] highest_idx(input logic [3:0] v);
    highest_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) highest_idx = 2'(i);
    end
  endfunction

  // Out-of-range floor readings fall back to the ground floor.
  always_comb begin
    cur_idx = 2'd0;
    if (bus.in_cur_f >= 3'd1 && bus.in_cur_f <= 3'd4) begin
      cur_idx = 2'(bus.in_cur_f - 3'd1);
    end
  end

  assign ge_mask    = 4'b1111 << cur_idx;
  assign le_mask    = 4'b1111 >> (2'd3 - cur_idx);
  assign up_hits    = pending_q & ge_mask;
  assign below_hits = pending_q & ~ge_mask;
  assign down_hits  = pending_q & le_mask;
  assign above_hits = pending_q & ~le_mask;

  always_comb begin
    sel_f   = 2'd0;
    sel_dir = dir_q;
    if (dir_q) begin
      if (|up_hits) begin
        sel_f = lowest_idx(up_hits);
      end else begin
        sel_f   = highest_idx(below_hits);
        sel_dir = 1'b0;
      end
    end else begin
      if (|down_hits) begin
        sel_f = highest_idx(down_hits);
      end else begin
        sel_f   = lowest_idx(above_hits);
        sel_dir = 1'b1;
      end
    end
  end

  assign arrived = bus.in_reached && (bus.in_cur_f == ({1'b0, f_q} + 3'd1));

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    clr_mask  = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        f_d     = sel_f;
        dir_d   = sel_dir;
        state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Arrival wins over an expiring counter in the same cycle.
        if (arrived) begin
          state_d = ST_CLEAR;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        clr_mask = 4'b0001 << f_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A press in the clearing cycle re-arms the call it would otherwise clear.
  assign pending_d = (pending_q & ~clr_mask) | bus.in_btn;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 4'b0000;
      dir_q     <= 1'b1;
      f_q       <= 2'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      f_q       <= f_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_f       = f_q;
  assign bus.o_valid   = (state_q == ST_DISPATCH) || (state_q == ST_WAIT);
  assign bus.o_pending = pending_q;
  assign bus.o_dir     = dir_q;
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_timeout = timeout_q;

endmodule

// File: doc/lift_call_dispatcher.md
LIFT_CALL_DISPATCHER -- requirements
Module: lift_call_dispatcher

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the cycles allowed in WAIT before abort. Legal range is 2..255.
REQ-003 in_clk  input  1  rising-edge clock for all state.
REQ-004 in_rst_n  input  1  synchronous active-low reset, sampled on in_clk.
REQ-005 in_btn  input  4  floor call buttons, bit i = floor i+1, level-sampled each cycle.
REQ-006 in_cur_f  input  3  current lift floor, 1-based (1..4), from the lift controller's floor output.
REQ-007 in_reached  input  1  lift "reached target" flag from the lift controller.
REQ-008 o_f  output  2  target floor index (0..3) driven to the lift controller's floor request input.
REQ-009 o_valid  output  1  o_f is a live request.
REQ-010 o_pending  output  4  latched outstanding calls (button lamps).
REQ-011 o_dir  output  1  scan direction: 1 = up, 0 = down.
REQ-012 o_busy  output  1  FSM is not in IDLE.
REQ-013 o_timeout  output  1  one-cycle pulse on a WAIT abort.

Function
REQ-014 Pending latch: pending <= (pending & ~clr_mask) | in_btn every cycle.
  - clr_mask is non-zero only in CLEAR.
  - A set in the same cycle as a clear of the same bit SHALL win.
REQ-015 FSM states SHALL be IDLE, SELECT, DISPATCH, WAIT, CLEAR, all registered.
REQ-016 IDLE -> SELECT when pending != 0; otherwise the FSM stays in IDLE.
REQ-017 Current index c SHALL be in_cur_f-1. Values of in_cur_f outside 1..4 SHALL be treated as c = 0.
REQ-018 SELECT, when dir = up:
  - If any pending index >= c exists, target SHALL be the lowest such index and dir is kept.
  - Otherwise target SHALL be the highest pending index < c and dir SHALL flip to down.
REQ-019 SELECT, when dir = down: mirror image of REQ-018.
  - Highest pending index <= c, keeping dir.
  - Otherwise lowest pending index > c, flipping dir to up.
REQ-020 SELECT SHALL register target into o_f and move to DISPATCH. Pending at index c counts in either direction.
REQ-021 DISPATCH SHALL last exactly one cycle, then move to WAIT; the timeout counter SHALL clear.
REQ-022 o_valid SHALL be 1 in DISPATCH and WAIT, and 0 in all other states.
REQ-023 o_f SHALL hold stable from DISPATCH through CLEAR.
REQ-024 WAIT -> CLEAR when in_reached = 1 and in_cur_f = o_f+1 in the same cycle.
  - in_reached with a mismatched floor SHALL be ignored.
REQ-025 WAIT: the counter SHALL increment each cycle. When the counter reaches TIMEOUT-1 without arrival:
  - o_timeout SHALL pulse for one cycle;
  - pending is kept;
  - the FSM returns to IDLE.
REQ-026 Arrival SHALL take priority over timeout in the same cycle.
REQ-027 CLEAR SHALL clear pending[o_f] (subject to REQ-014) and return to IDLE after one cycle.
REQ-028 Latency: a press sampled at edge k SHALL give o_valid = 1 after edge k+2, provided the FSM was in IDLE.
REQ-029 Presses arriving while busy SHALL only set pending bits. They SHALL never retarget the in-flight request.
REQ-030 o_busy SHALL equal (state != IDLE). o_pending SHALL equal pending. o_dir SHALL equal dir.

Reset
REQ-031 While in_rst_n = 0 at an edge, all of the following SHALL hold next cycle, regardless of state:
  - state = IDLE; pending = 0; dir = 1;
  - o_f = 0; counter = 0;
  - o_valid = 0, o_busy = 0, o_timeout = 0.
REQ-032 Button presses coincident with reset SHALL be discarded.

Verification
REQ-033 Single call: cur = 1, pulse in_btn = 4'b1000 -> o_valid = 1, o_f = 3 two cycles later.
  - Then drive in_cur_f = 4 with in_reached = 1 -> o_pending = 0 and o_busy = 0 two cycles later.
REQ-034 SCAN order: cur = 2, dir = up, pending = 4'b1001 -> first target o_f = 3.
  - After arrival, next target o_f = 0 with o_dir = 0.
REQ-035 Call at current floor: cur = 3, in_reached = 1, press bit 2 -> o_f = 2, then pending cleared with no timeout.
REQ-036 Timeout, TIMEOUT = 8: hold in_reached = 0 -> o_timeout pulses for one cycle, o_pending is unchanged, and the block re-dispatches.
REQ-037 Reset mid-WAIT: assert in_rst_n = 0 for one edge -> o_valid = 0, o_pending = 0, o_dir = 1 next cycle.
REQ-038 Set/clear collision: press bit o_f in the CLEAR cycle -> the bit stays set and is re-dispatched.
